// File: rtl/times_table_writer.sv
// Fill engine for the 8x8 times-table RAM: walks every {a,b} address in a-major order
// and writes a*b, building each product by repeated addition of a.
module times_table_writer #(
    parameter int OP_W   = 3,
    parameter int ADDR_W = 2 * OP_W,
    parameter int DATA_W = 2 * OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Write port handshake: wr_en/wr_addr/wr_data stay stable until an edge with
    // wr_en=1 and wr_ready=1; that edge is the accept and the next entry follows.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_MAX = '1;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        wr_en_d = wr_en_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WRITE;
                    a_d     = '0;
                    b_d     = '0;
                    acc_d   = '0;
                    wr_en_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (b_q == OP_MAX) begin
                        // Row finished: acc restarts at 0*(a+1); a wraps to 0 after the last row.
                        b_d   = '0;
                        acc_d = '0;
                        a_d   = a_q + OP_W'(1);
                        if (a_q == OP_MAX) begin
                            state_d = DONE;
                            wr_en_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        b_d   = b_q + OP_W'(1);
                        acc_d = acc_q + DATA_W'(a_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = ADDR_W'({a_q, b_q});
    assign wr_data   = acc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_times_table_writer.sv
// Bench for times_table_writer: a queue of the 64 expected {addr,data} writes is the
// reference; outputs are checked against it on every falling edge.
module tb_times_table_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       wr_ready = 1'b1;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [5:0] wr_data;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int total = 0;
    int bad = 0;

    times_table_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes in order, plus done flag and fill timing.
    logic [11:0] exp_q[$];
    logic        m_done = 1'b0;
    int          edge_cnt = 0;
    int          start_edge = 0;
    int          fill_len = 0;
    int          stalls = 0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        if (!rst_n) begin
            exp_q.delete();
            m_done = 1'b0;
        end else if (exp_q.size() == 0 && start) begin
            for (int n = 0; n < 64; n++) begin
                logic [5:0] ad, dd;
                ad = 6'(n);
                dd = 6'((n / 8) * (n % 8));
                exp_q.push_back({ad, dd});
            end
            m_done     = 1'b0;
            start_edge = edge_cnt;
            stalls     = 0;
        end else if (exp_q.size() != 0) begin
            if (wr_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_done   = 1'b1;
                    fill_len = edge_cnt - start_edge;
                end
            end else begin
                stalls = stalls + 1;
            end
        end
    end

    function automatic void chk(string name, int act, int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en", int'(wr_en), int'(exp_q.size() != 0));
            chk("busy", int'(busy), int'(exp_q.size() != 0));
            chk("done", int'(done), int'(m_done));
            if (exp_q.size() != 0) begin
                chk("wr_addr", int'(wr_addr), int'(exp_q[0][11:6]));
                chk("wr_data", int'(wr_data), int'(exp_q[0][5:0]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_addr(input logic [5:0] target, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (wr_en && wr_addr == target) found = 1'b1;
            else tick();
        end
        if (!found && wr_en && wr_addr == target) found = 1'b1;
        chk($sformatf("reach_addr_%0d", target), int'(found), 1);
    endtask

    task automatic wait_done(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (done) found = 1'b1;
            else tick();
        end
        if (!found && done) found = 1'b1;
        chk("reach_done", int'(found), 1);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // Full fill with wr_ready held high, literal spot checks
        wr_ready = 1'b1;
        pulse_start();
        chk("first_addr", int'(wr_addr), 0);
        wait_addr(6'h07, 100);
        chk("data_07", int'(wr_data), 0);
        wait_addr(6'h2B, 100);
        chk("data_2b", int'(wr_data), 15);
        wait_addr(6'h3F, 100);
        chk("data_3f", int'(wr_data), 49);
        wait_done(100);
        chk("fill_len_full", fill_len, 64);
        repeat (5) tick();
        chk("no_wr_after_done", int'(wr_en), 0);

        // Backpressure: three stalled cycles at address 0x12
        pulse_start();
        chk("restart_done_low", int'(done), 0);
        chk("restart_addr0", int'(wr_addr), 0);
        wait_addr(6'h12, 100);
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_addr_12", int'(wr_addr), 18);
            chk("hold_data_12", int'(wr_data), 4);
        end
        wr_ready = 1'b1;
        wait_done(200);
        chk("fill_len_bp", fill_len, 67);

        // Start during busy is ignored
        pulse_start();
        wait_addr(6'd20, 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("no_restart_addr", int'(wr_addr), 21);
        wait_done(100);
        chk("fill_len_ignore", fill_len, 64);

        // Randomised backpressure
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            for (int i = 0; i < 2000 && !done; i++) begin
                wr_ready = 1'($urandom_range(0, 1));
                tick();
            end
            wr_ready = 1'b1;
            wait_done(100);
            chk("fill_len_rand", fill_len, 64 + stalls);
        end

        // Reset mid-fill, then a fresh fill
        pulse_start();
        wait_addr(6'd40, 100);
        rst_n = 1'b0;
        tick();
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        rst_n = 1'b1;
        tick();
        chk("midrst_idle_done", int'(done), 0);
        pulse_start();
        chk("fresh_addr0", int'(wr_addr), 0);
        wait_done(100);
        chk("fill_len_fresh", fill_len, 64);

        // Reset and start on the same edge: reset wins
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_start_wr_en", int'(wr_en), 0);
        chk("rst_start_done", int'(done), 0);
        tick();
        chk("rst_start_idle", int'(wr_en), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/times_table_writer.md
# times_table_writer

Fill engine for the 0..7 x 0..7 times-table memory. On a start pulse it walks all 64 `{a,b}` addresses and writes each product `a*b` into the table RAM over a valid/ready write port. Products are built by repeated addition, with no multiplier in the datapath. It is the write side of the table that the multiplier read path later uses, and runs once after reset or whenever the table must be rebuilt.

## Interface
Parameters:
- `OP_W`, 3: operand width (a and b each 0..2^OP_W-1)
- `ADDR_W`, 2*OP_W: table address width, address = `{a,b}`
- `DATA_W`, 2*OP_W: product width; 6 bits holds 7*7=49 without truncation

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge
- `rst_n`, in, 1: synchronous, active-low reset
- `start`, in, 1: request a full table fill; sampled only in IDLE or DONE
- `wr_ready`, in, 1: memory accepts the write presented this cycle
- `wr_en`, out, 1: write valid
- `wr_addr`, out, ADDR_W: `{a,b}`, a in the MSBs
- `wr_data`, out, DATA_W: a*b for the presented address
- `busy`, out, 1: fill in progress
- `done`, out, 1: table complete; held high until the next start or reset

## Operation
- FSM states: IDLE, WRITE, DONE.
- Reset (`rst_n`=0 at an edge): state goes to IDLE. `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0. All outputs are registered.
- IDLE -> WRITE on `start`=1. Loads a=0, b=0, acc=0, and sets `busy`=1, `done`=0.
- In WRITE, `wr_en`=1, `wr_addr`={a,b} and `wr_data`=acc.
- A write is accepted on any edge where `wr_en`=1 and `wr_ready`=1.
- On accept, the counters advance:
  - b<7: b=b+1, acc=acc+a.
  - b=7: b=0, acc=0, a=a+1.
- Without accept, a, b, acc and all write outputs hold stable. There is no timeout.
- Acc never exceeds 49, so no overflow is possible at DATA_W=6.
- Order is a-major: addresses 0,1,...,63.
- Accept at address 63 moves the FSM to DONE: `wr_en`=0, `busy`=0, `done`=1.
- In DONE, `start`=1 restarts the fill, identical to the IDLE->WRITE transition, and clears `done`.
- `start` in WRITE is ignored; there is no restart mid-fill.
- Reset mid-fill aborts immediately. The partially written table is not cleaned up, and `done` stays 0 until a full fill completes.
- `rst_n`=0 together with `start`=1: reset wins.
- `wr_ready` is ignored outside WRITE.

## Timing
- `start` sampled at edge 0: `wr_en`=1 with addr 0 from edge 1.
- With `wr_ready` held at 1, one write is accepted per cycle:
  - Addresses 0..63 are presented in cycles 1..64.
  - At edge 65, `done`=1 and `busy`=0.
- Each cycle of `wr_ready`=0 during WRITE adds exactly one cycle to the fill.
- `busy` and `wr_en` are equal in every cycle.
- A restart from DONE has the same start-to-first-write latency of one cycle.

## Test plan
- Full fill, `wr_ready`=1: start pulse, then capture 64 writes.
  - Expect addr n with data (n>>3)*(n&7), e.g. addr 0x2B -> 15, addr 0x3F -> 49, addr 0x07 -> 0.
  - Expect `done` at cycle 65 and no further `wr_en` afterwards.
- Backpressure:
  - Drop `wr_ready` for 3 cycles while addr 0x12 is presented. `wr_addr` and `wr_data` hold 0x12 and 4, and the total fill is 67 cycles.
  - Randomise `wr_ready`. The scoreboard still sees 64 accepted writes, each exactly once and in order.
- Start during busy: pulse `start` at address 20. The sequence continues 21, 22, ... unchanged, with no restart.
- Reset mid-fill: assert `rst_n`=0 at address 40. Next edge: `wr_en`=0, `busy`=0, `done`=0. Then `start` gives a fresh fill from address 0.
- Restart from DONE: after completion, pulse `start`. `done` falls on that edge, addr 0 is presented the next cycle, and 64 correct writes follow.
- Simultaneous reset and start: `rst_n`=0 and `start`=1 on the same edge. The FSM stays in IDLE with `wr_en`=0.
